// File: rtl/arcade_input_hub.sv
// Control-input concentrator: merges PS/2 keyboard, joystick and JAMMA inputs into
// registered active-low player vectors with coin stretching, SOCD cleaning and pause.
`timescale 1ns/1ps

module arcade_input_hub #(
    parameter int          PLAYERS     = 2,
    parameter int          BUTTONS     = 2,
    parameter int unsigned COIN_CYCLES = 32'd50000,
    parameter int          SOCD        = 0
) (
    input  logic                            clk_sys,
    input  logic                            rst_n,
    input  logic [10:0]                     ps2_key,
    input  logic [PLAYERS*(7+BUTTONS)-1:0]  joy,
    input  logic [PLAYERS*(6+BUTTONS)-1:0]  jamma,
    input  logic                            clear_pause,
    output logic [PLAYERS*(4+BUTTONS)-1:0]  joy_n,
    output logic [PLAYERS-1:0]              start_n,
    output logic [PLAYERS-1:0]              coin_n,
    output logic                            pause
);

    localparam int JW         = 7 + BUTTONS;
    localparam int MW         = 6 + BUTTONS;
    localparam int OW         = 4 + BUTTONS;
    localparam int CW         = $clog2(COIN_CYCLES + 1);
    localparam int KB_START_N = (PLAYERS > 1) ? 2 : 1;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);
    localparam logic [7:0] FIRE_CODE  [4] = '{8'h14, 8'h29, 8'h11, 8'h12};
    localparam logic [7:0] START_CODE [2] = '{8'h05, 8'h06};

    logic                    primed_r;
    logic                    key_tog_r;
    logic [3:0]              kb_dir_r;
    logic [BUTTONS-1:0]      kb_fire_r;
    logic [KB_START_N-1:0]   kb_start_r;
    logic                    kb_coin_r;
    logic                    kb_pause_r;
    logic                    unused_ext_s;

    logic [3:0]              dir_s      [PLAYERS];
    logic [BUTTONS-1:0]      fire_s     [PLAYERS];
    logic [PLAYERS-1:0]      start_s;
    logic [PLAYERS-1:0]      coin_s;
    logic                    pause_src_s;

    logic [3:0]              prev_dir_r [PLAYERS];
    logic [3:0]              rise_s     [PLAYERS];
    logic [3:0]              res_s      [PLAYERS];
    logic [1:0]              last_r     [PLAYERS];
    logic [1:0]              tie_r      [PLAYERS];

    logic [CW-1:0]           cnt_r      [PLAYERS];
    logic [CW-1:0]           cnt_nxt_s  [PLAYERS];
    logic [PLAYERS-1:0]      coin_prev_r;
    logic                    pause_prev_r;

    logic [PLAYERS*OW-1:0]   joy_n_r;
    logic [PLAYERS-1:0]      start_n_r;
    logic [PLAYERS-1:0]      coin_n_r;
    logic                    pause_r;

    assign unused_ext_s = ps2_key[8];
    assign joy_n   = joy_n_r;
    assign start_n = start_n_r;
    assign coin_n  = coin_n_r;
    assign pause   = pause_r;

    // Keyboard event decode; the first cycle out of reset only adopts the current toggle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            primed_r   <= 1'b0;
            key_tog_r  <= 1'b0;
            kb_dir_r   <= 4'b0000;
            kb_fire_r  <= '0;
            kb_start_r <= '0;
            kb_coin_r  <= 1'b0;
            kb_pause_r <= 1'b0;
        end else if (!primed_r) begin
            primed_r  <= 1'b1;
            key_tog_r <= ps2_key[10];
        end else if (ps2_key[10] != key_tog_r) begin
            key_tog_r <= ps2_key[10];
            case (ps2_key[7:0])
                8'h74:   kb_dir_r[0] <= ps2_key[9];
                8'h6B:   kb_dir_r[1] <= ps2_key[9];
                8'h72:   kb_dir_r[2] <= ps2_key[9];
                8'h75:   kb_dir_r[3] <= ps2_key[9];
                8'h04:   kb_coin_r   <= ps2_key[9];
                8'h0C:   kb_pause_r  <= ps2_key[9];
                default: kb_dir_r    <= kb_dir_r;
            endcase
            for (int b = 0; b < BUTTONS; b++) begin
                if (ps2_key[7:0] == FIRE_CODE[b]) kb_fire_r[b] <= ps2_key[9];
            end
            for (int p = 0; p < KB_START_N; p++) begin
                if (ps2_key[7:0] == START_CODE[p]) kb_start_r[p] <= ps2_key[9];
            end
        end
    end

    // Source merge; keyboard flags only feed player 0 (and player 1 start).
    always_comb begin
        pause_src_s = kb_pause_r;
        for (int p = 0; p < PLAYERS; p++) begin
            dir_s[p]    = joy[p*JW +: 4] | jamma[p*MW +: 4];
            fire_s[p]   = joy[p*JW+4 +: BUTTONS] | jamma[p*MW+4 +: BUTTONS];
            start_s[p]  = joy[p*JW+4+BUTTONS] | jamma[p*MW+4+BUTTONS];
            coin_s[p]   = joy[p*JW+5+BUTTONS] | jamma[p*MW+5+BUTTONS];
            pause_src_s = pause_src_s | joy[p*JW+6+BUTTONS];
        end
        dir_s[0]                   = dir_s[0] | kb_dir_r;
        fire_s[0]                  = fire_s[0] | kb_fire_r;
        start_s[KB_START_N-1:0]    = start_s[KB_START_N-1:0] | kb_start_r;
        coin_s[0]                  = coin_s[0] | kb_coin_r;
    end

    // Opposing-direction resolution per axis: bit 2x is right/down, bit 2x+1 is left/up.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            rise_s[p] = dir_s[p] & ~prev_dir_r[p];
            res_s[p]  = dir_s[p];
            for (int x = 0; x < 2; x++) begin
                if (SOCD == 1 && dir_s[p][2*x] && dir_s[p][2*x+1]) begin
                    res_s[p][2*x +: 2] = 2'b00;
                end else if (SOCD == 2 && dir_s[p][2*x] && dir_s[p][2*x+1]) begin
                    if (rise_s[p][2*x] && rise_s[p][2*x+1]) begin
                        res_s[p][2*x +: 2] = 2'b00;
                    end else if (rise_s[p][2*x]) begin
                        res_s[p][2*x +: 2] = 2'b01;
                    end else if (rise_s[p][2*x+1]) begin
                        res_s[p][2*x +: 2] = 2'b10;
                    end else if (tie_r[p][x]) begin
                        res_s[p][2*x +: 2] = 2'b00;
                    end else if (last_r[p][x]) begin
                        res_s[p][2*x +: 2] = 2'b10;
                    end else begin
                        res_s[p][2*x +: 2] = 2'b01;
                    end
                end else begin
                    res_s[p][2*x +: 2] = dir_s[p][2*x +: 2];
                end
            end
        end
    end

    // Last-rise memory and tie flag; a tie holds neutral until either side is released.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PLAYERS; p++) begin
                prev_dir_r[p] <= 4'b0000;
                last_r[p]     <= 2'b00;
                tie_r[p]      <= 2'b00;
            end
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                prev_dir_r[p] <= dir_s[p];
                for (int x = 0; x < 2; x++) begin
                    if (rise_s[p][2*x] && rise_s[p][2*x+1]) begin
                        tie_r[p][x] <= 1'b1;
                    end else if (rise_s[p][2*x]) begin
                        last_r[p][x] <= 1'b0;
                        tie_r[p][x]  <= 1'b0;
                    end else if (rise_s[p][2*x+1]) begin
                        last_r[p][x] <= 1'b1;
                        tie_r[p][x]  <= 1'b0;
                    end else if (!(dir_s[p][2*x] && dir_s[p][2*x+1])) begin
                        tie_r[p][x] <= 1'b0;
                    end else begin
                        tie_r[p][x] <= tie_r[p][x];
                    end
                end
            end
        end
    end

    // Next coin counter value; edges during an active stretch do not reload.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            if (cnt_r[p] != '0) begin
                cnt_nxt_s[p] = cnt_r[p] - CW'(1);
            end else if (coin_s[p] && !coin_prev_r[p]) begin
                cnt_nxt_s[p] = COIN_LOAD;
            end else begin
                cnt_nxt_s[p] = '0;
            end
        end
    end

    // Coin counters and edge history.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            coin_prev_r <= '0;
            for (int p = 0; p < PLAYERS; p++) cnt_r[p] <= '0;
        end else begin
            coin_prev_r <= coin_s;
            for (int p = 0; p < PLAYERS; p++) cnt_r[p] <= cnt_nxt_s[p];
        end
    end

    // Registered active-low player outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            joy_n_r   <= '1;
            start_n_r <= '1;
            coin_n_r  <= '1;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                joy_n_r[p*OW +: OW] <= ~{fire_s[p], res_s[p]};
                start_n_r[p]        <= ~start_s[p];
                coin_n_r[p]         <= ~((cnt_nxt_s[p] != '0) | coin_s[p]);
            end
        end
    end

    // Pause toggles on a source rising edge; clear_pause has priority.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pause_prev_r <= 1'b0;
            pause_r      <= 1'b0;
        end else begin
            pause_prev_r <= pause_src_s;
            if (clear_pause) begin
                pause_r <= 1'b0;
            end else if (pause_src_s && !pause_prev_r) begin
                pause_r <= ~pause_r;
            end else begin
                pause_r <= pause_r;
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_hub.sv
// Scoreboard bench for arcade_input_hub: stimulus queues expected output values with
// a due cycle, a negedge monitor compares them when that cycle arrives.
`timescale 1ns/1ps

module tb_arcade_input_hub;

    localparam int K_JA = 0;
    localparam int K_ST = 1;
    localparam int K_CO = 2;
    localparam int K_PA = 3;
    localparam int K_JB = 4;
    localparam int K_CB = 5;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [17:0] joy;
    logic [15:0] jamma;
    logic        clear_pause;
    logic [11:0] joy_n_a, joy_n_b;
    logic [1:0]  start_n_a, start_n_b, coin_n_a, coin_n_b;
    logic        pause_a, pause_b;

    always #5 clk_sys = ~clk_sys;

    arcade_input_hub #(.PLAYERS(2), .BUTTONS(2), .COIN_CYCLES(32'd8), .SOCD(2)) dut_a (
        .clk_sys(clk_sys), .rst_n(rst_n), .ps2_key(ps2_key), .joy(joy), .jamma(jamma),
        .clear_pause(clear_pause), .joy_n(joy_n_a), .start_n(start_n_a),
        .coin_n(coin_n_a), .pause(pause_a)
    );

    arcade_input_hub #(.PLAYERS(2), .BUTTONS(2), .COIN_CYCLES(32'd8), .SOCD(1)) dut_b (
        .clk_sys(clk_sys), .rst_n(rst_n), .ps2_key(ps2_key), .joy(joy), .jamma(jamma),
        .clear_pause(clear_pause), .joy_n(joy_n_b), .start_n(start_n_b),
        .coin_n(coin_n_b), .pause(pause_b)
    );

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] mon_act;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [15:0] actual(int kind);
        case (kind)
            K_JA:    return {4'h0, joy_n_a};
            K_ST:    return {14'h0, start_n_a};
            K_CO:    return {14'h0, coin_n_a};
            K_PA:    return {15'h0, pause_a};
            K_JB:    return {4'h0, joy_n_b};
            K_CB:    return {14'h0, coin_n_b} | {15'h0, pause_b} << 2 | {14'h0, start_n_b} << 3;
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_act = actual(sb[i].kind);
                n_vec++;
                if (mon_act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %h expected %h",
                             sb[i].name, cyc, mon_act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int lat, input int kind, input logic [15:0] v, input string name);
        sb.push_back('{cyc + lat, kind, v, name});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    initial begin
        rst_n       = 1'b0;
        ps2_key     = {1'b1, 1'b1, 1'b0, 8'h29};
        joy         = '0;
        jamma       = '0;
        clear_pause = 1'b0;
        step(2);
        expect_at(0, K_JA, 16'h0FFF, "rst_joy_n");
        expect_at(0, K_ST, 16'h0003, "rst_start_n");
        expect_at(0, K_CO, 16'h0003, "rst_coin_n");
        expect_at(0, K_PA, 16'h0000, "rst_pause");
        expect_at(0, K_CB, 16'h001B, "rst_dut_b");
        step(1);

        // Release with toggle already high: no key event.
        rst_n = 1'b1;
        expect_at(2, K_JA, 16'h0FFF, "prime_no_event");
        expect_at(3, K_JA, 16'h0FFF, "prime_no_event_late");
        step(4);

        // Keyboard decode, two-cycle latency.
        key(1'b1, 8'h29);
        expect_at(1, K_JA, 16'h0FFF, "kb_fire1_not_yet");
        expect_at(2, K_JA, 16'h0FDF, "kb_fire1_press");
        step(4);
        key(1'b0, 8'h29); expect_at(2, K_JA, 16'h0FFF, "kb_fire1_release"); step(4);
        key(1'b1, 8'h12); expect_at(2, K_JA, 16'h0FFF, "kb_fire3_ignored"); step(4);
        key(1'b1, 8'h14); expect_at(2, K_JA, 16'h0FEF, "kb_fire0_press");   step(4);
        key(1'b0, 8'h14); expect_at(2, K_JA, 16'h0FFF, "kb_fire0_release"); step(4);
        key(1'b1, 8'h06); expect_at(2, K_ST, 16'h0001, "kb_start_p1");      step(4);
        key(1'b0, 8'h06); expect_at(2, K_ST, 16'h0003, "kb_start_p1_rel");  step(4);
        key(1'b1, 8'h33); expect_at(2, K_JA, 16'h0FFF, "kb_unlisted");      step(4);

        // Each source alone drives P0 up.
        key(1'b1, 8'h75); expect_at(2, K_JA, 16'h0FF7, "kb_up");     step(4);
        key(1'b0, 8'h75); expect_at(2, K_JA, 16'h0FFF, "kb_up_rel"); step(4);
        joy[3] = 1'b1;
        expect_at(0, K_JA, 16'h0FFF, "joy_up_not_yet");
        expect_at(1, K_JA, 16'h0FF7, "joy_up");
        step(3);
        joy[3] = 1'b0;   expect_at(1, K_JA, 16'h0FFF, "joy_up_rel");   step(3);
        jamma[3] = 1'b1; expect_at(1, K_JA, 16'h0FF7, "jamma_up");     step(3);
        jamma[3] = 1'b0; expect_at(1, K_JA, 16'h0FFF, "jamma_up_rel"); step(3);
        joy[9] = 1'b1;   expect_at(1, K_JA, 16'h0FBF, "joy_p1_right"); step(3);
        joy[9] = 1'b0;   step(3);
        jamma[14] = 1'b1; expect_at(1, K_ST, 16'h0001, "jamma_p1_start"); step(3);
        jamma[14] = 1'b0; expect_at(1, K_ST, 16'h0003, "jamma_p1_start_rel"); step(3);

        // SOCD: dut_a last-pressed wins, dut_b cancels.
        joy[0] = 1'b1;
        expect_at(1, K_JA, 16'h0FFE, "socd2_right");
        expect_at(1, K_JB, 16'h0FFE, "socd1_right");
        step(3);
        joy[1] = 1'b1;
        expect_at(1, K_JA, 16'h0FFD, "socd2_left_wins");
        expect_at(3, K_JA, 16'h0FFD, "socd2_left_held");
        expect_at(1, K_JB, 16'h0FFF, "socd1_cancel");
        step(4);
        joy[1] = 1'b0;
        expect_at(1, K_JA, 16'h0FFE, "socd2_back_right");
        expect_at(1, K_JB, 16'h0FFE, "socd1_back_right");
        step(3);
        joy[0] = 1'b0; step(3);
        jamma[1:0] = 2'b11;
        expect_at(1, K_JA, 16'h0FFF, "socd2_tie");
        expect_at(3, K_JA, 16'h0FFF, "socd2_tie_held");
        step(4);
        jamma[1] = 1'b0; expect_at(1, K_JA, 16'h0FFE, "socd2_tie_release"); step(3);
        jamma[0] = 1'b0; step(3);

        // Coin stretch: single pulse.
        for (int d = 0; d <= 9; d++)
            expect_at(d, K_CO, (d >= 1 && d <= 8) ? 16'h0001 : 16'h0003, "coin_pulse");
        joy[16] = 1'b1; step(1); joy[16] = 1'b0; step(12);
        // Second pulse inside the stretch does not extend.
        for (int d = 0; d <= 9; d++)
            expect_at(d, K_CO, (d >= 1 && d <= 8) ? 16'h0001 : 16'h0003, "coin_no_extend");
        joy[16] = 1'b1; step(1); joy[16] = 1'b0; step(3);
        joy[16] = 1'b1; step(1); joy[16] = 1'b0; step(12);
        // Held longer than the stretch.
        for (int d = 0; d <= 21; d++)
            expect_at(d, K_CO, (d >= 1 && d <= 20) ? 16'h0001 : 16'h0003, "coin_held");
        joy[16] = 1'b1; step(20); joy[16] = 1'b0; step(4);

        // Pause toggles from F4 presses.
        key(1'b1, 8'h0C);
        expect_at(1, K_PA, 16'h0000, "pause_not_yet");
        expect_at(2, K_PA, 16'h0001, "pause_first");
        step(4);
        key(1'b0, 8'h0C); expect_at(2, K_PA, 16'h0001, "pause_release_hold"); step(4);
        key(1'b1, 8'h0C); expect_at(2, K_PA, 16'h0000, "pause_second");       step(4);
        key(1'b0, 8'h0C); step(4);
        key(1'b1, 8'h0C); expect_at(2, K_PA, 16'h0001, "pause_third");        step(4);
        key(1'b0, 8'h0C); step(4);
        clear_pause = 1'b1; expect_at(1, K_PA, 16'h0000, "pause_clear"); step(1);
        clear_pause = 1'b0; step(2);
        clear_pause = 1'b1; joy[8] = 1'b1;
        expect_at(1, K_PA, 16'h0000, "pause_clear_wins");
        step(1);
        clear_pause = 1'b0; step(2);
        joy[8] = 1'b0; step(2);
        joy[8] = 1'b1; expect_at(1, K_PA, 16'h0001, "pause_joy"); step(2);
        joy[8] = 1'b0; step(2);

        // Asynchronous reset during a coin stretch with pause set.
        expect_at(1, K_PA, 16'h0001, "pause_before_rst");
        jamma[7] = 1'b1;
        expect_at(1, K_CO, 16'h0002, "coin_p0_stretch");
        step(1);
        jamma[7] = 1'b0; step(2);
        rst_n   = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h0C};
        expect_at(0, K_CO, 16'h0003, "rst_coin_async");
        expect_at(0, K_PA, 16'h0000, "rst_pause_async");
        step(2);
        rst_n = 1'b1;
        for (int d = 1; d <= 4; d++) expect_at(d, K_PA, 16'h0000, "rst_release_no_event");
        expect_at(3, K_CO, 16'h0003, "rst_release_coin");
        expect_at(3, K_JA, 16'h0FFF, "rst_release_joy");
        step(6);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
            n_fail += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
